fft_frame_sequencer: RTL and testbench

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

---
 rtl/fft_frame_sequencer_if.sv | 50 +++++
 rtl/fft_frame_sequencer.sv | 159 +++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_sequencer_if.sv
// Handshake and status bundle between the frame sequencer and the ADC/FFT datapath.
// The sequencer takes the master side; the sink/controller side takes the slave side.
interface fft_frame_sequencer_if #(
    parameter int unsigned NSINK = 3
);
    localparam int unsigned SelW = $clog2(NSINK);

    logic            enable;
    logic            fft_ready;
    logic            fft_done;
    logic            cap_valid;
    logic            cap_sop;
    logic            cap_eop;
    logic [SelW-1:0] sel_a;
    logic [SelW-1:0] sel_b;
    logic            result_strobe;
    logic            busy;
    logic            overrun;
    logic            timeout_err;

    modport master (
        input  enable,
        input  fft_ready,
        input  fft_done,
        output cap_valid,
        output cap_sop,
        output cap_eop,
        output sel_a,
        output sel_b,
        output result_strobe,
        output busy,
        output overrun,
        output timeout_err
    );

    modport slave (
        output enable,
        output fft_ready,
        output fft_done,
        input  cap_valid,
        input  cap_sop,
        input  cap_eop,
        input  sel_a,
        input  sel_b,
        input  result_strobe,
        input  busy,
        input  overrun,
        input  timeout_err
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Schedules one N-sample FFT frame per frame tick, stepping through every ADC channel pair
// in lexicographic order and flagging missed ticks and FFT result timeouts.
module fft_frame_sequencer #(
    parameter int unsigned NSINK   = 3,
    parameter int unsigned FFT     = 11,
    parameter int unsigned FREQ    = 5000,
    parameter int unsigned CLKHZ   = 40000000,
    parameter int unsigned TIMEOUT = 65535
) (
    input logic                   clk40,
    input logic                   reset,
    fft_frame_sequencer_if.master bus
);
    localparam int unsigned N      = 2 ** FFT;
    localparam int unsigned PERIOD = CLKHZ / FREQ;
    localparam int unsigned SelW   = $clog2(NSINK);
    localparam int unsigned TickW  = $clog2(PERIOD);
    localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);

    localparam logic [TickW-1:0] TickLast = TickW'(PERIOD - 1);
    localparam logic [FFT-1:0]   SampLast = FFT'(N - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
    localparam logic [SelW-1:0]  LastB    = SelW'(NSINK - 1);
    localparam logic [SelW-1:0]  LastA    = SelW'(NSINK - 2);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StWaitTick = 3'd1;
    localparam logic [2:0] StCapture  = 3'd2;
    localparam logic [2:0] StDrain    = 3'd3;
    localparam logic [2:0] StAdvance  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic [FFT-1:0]   samp_cnt_q, samp_cnt_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [SelW-1:0]  sel_a_q, sel_a_d;
    logic [SelW-1:0]  sel_b_q, sel_b_d;
    logic             strobe_q, strobe_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    logic tick;
    logic in_frame;
    logic capturing;
    logic accept;

    assign capturing = (state_q == StCapture);
    assign in_frame  = (state_q == StCapture) || (state_q == StDrain) || (state_q == StAdvance);
    assign accept    = capturing && bus.fft_ready;
    assign tick      = bus.enable && (tick_cnt_q == TickLast);

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (!bus.enable || tick) begin
            tick_cnt_d = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        wait_cnt_d = wait_cnt_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        strobe_d   = 1'b0;
        timeout_d  = timeout_q;
        // A tick that arrives while a frame is still in flight is dropped, not queued.
        overrun_d  = overrun_q | (tick & in_frame);

        case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d = StWaitTick;
                end
            end
            StWaitTick: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                end else if (tick) begin
                    state_d    = StCapture;
                    samp_cnt_d = '0;
                end
            end
            StCapture: begin
                if (accept) begin
                    if (samp_cnt_q == SampLast) begin
                        state_d    = StDrain;
                        samp_cnt_d = '0;
                        wait_cnt_d = '0;
                    end else begin
                        samp_cnt_d = samp_cnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (bus.fft_done) begin
                    state_d  = StAdvance;
                    strobe_d = 1'b1;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d   = StAdvance;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StAdvance: begin
                if (sel_b_q == LastB) begin
                    if (sel_a_q == LastA) begin
                        sel_a_d = '0;
                        sel_b_d = SelW'(1);
                    end else begin
                        sel_a_d = sel_a_q + 1'b1;
                        sel_b_d = sel_a_q + SelW'(2);
                    end
                end else begin
                    sel_b_d = sel_b_q + 1'b1;
                end
                state_d = bus.enable ? StWaitTick : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk40) begin
        if (!reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            wait_cnt_q <= '0;
            sel_a_q    <= '0;
            sel_b_q    <= SelW'(1);
            strobe_q   <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            sel_a_q    <= sel_a_d;
            sel_b_q    <= sel_b_d;
            strobe_q   <= strobe_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.cap_valid     = capturing;
    assign bus.cap_sop       = capturing && (samp_cnt_q == '0);
    assign bus.cap_eop       = capturing && (samp_cnt_q == SampLast);
    assign bus.sel_a         = sel_a_q;
    assign bus.sel_b         = sel_b_q;
    assign bus.result_strobe = strobe_q;
    assign bus.busy          = in_frame;
    assign bus.overrun       = overrun_q;
    assign bus.timeout_err   = timeout_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: a frame-level reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized ready/done/enable soak.
module tb_fft_frame_sequencer;
    localparam int NSINK   = 3;
    localparam int FFT     = 3;
    localparam int N       = 8;
    // PERIOD = 13: a nominal 10-cycle period leaves no room for drain and advance, so every
    // frame would overrun; 13 keeps back-to-back frames clean yet a 3-cycle stall overruns.
    localparam int FREQ    = 10;
    localparam int CLKHZ   = 130;
    localparam int PERIOD  = CLKHZ / FREQ;
    localparam int TIMEOUT = 20;
    localparam int NP      = NSINK * (NSINK - 1) / 2;

    localparam int MOff = 0, MWait = 1, MSend = 2, MResult = 3, MStep = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.NSINK(NSINK)) bus ();

    fft_frame_sequencer #(
        .NSINK  (NSINK),
        .FFT    (FFT),
        .FREQ   (FREQ),
        .CLKHZ  (CLKHZ),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk40(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pair k in lexicographic order, encoded a*16+b.
    function automatic int pair_code(input int k);
        int idx = 0;
        for (int a = 0; a < NSINK; a++) begin
            for (int b = a + 1; b < NSINK; b++) begin
                if (idx == k) return a * 16 + b;
                idx++;
            end
        end
        return -1;
    endfunction

    // Reference model: what the sequencer is doing, in frame-level terms.
    int m_mode, m_phase, m_sent, m_waited, m_pair;
    bit m_strobe, m_over, m_terr, m_live = 1'b0;

    always @(posedge clk) begin : model
        bit tk;
        if (!rst_n) begin
            m_mode = MOff; m_phase = 0; m_sent = 0; m_waited = 0; m_pair = 0;
            m_strobe = 0; m_over = 0; m_terr = 0; m_live = 1;
        end else begin
            tk = bus.enable && (m_phase == PERIOD - 1);
            m_phase = bus.enable ? (m_phase + 1) % PERIOD : 0;
            m_strobe = 0;
            if (tk && m_mode >= MSend) m_over = 1;
            case (m_mode)
                MOff:  if (bus.enable) m_mode = MWait;
                MWait: begin
                    if (!bus.enable) m_mode = MOff;
                    else if (tk) begin m_mode = MSend; m_sent = 0; end
                end
                MSend: if (bus.fft_ready) begin
                    m_sent++;
                    if (m_sent == N) begin m_mode = MResult; m_waited = 0; end
                end
                MResult: begin
                    m_waited++;
                    if (bus.fft_done) begin m_mode = MStep; m_strobe = 1; end
                    else if (m_waited == TIMEOUT) begin m_mode = MStep; m_terr = 1; end
                end
                default: begin
                    m_pair = (m_pair + 1) % NP;
                    m_mode = bus.enable ? MWait : MOff;
                end
            endcase
        end
    end

    int acc_cnt, sop_cnt, eop_cnt, valid_cnt, strobe_cnt, post_cnt;
    int frame_pairs[$];
    int strobe_pairs[$];

    always @(negedge clk) begin : compare
        int pc;
        pc = bus.sel_a * 16 + bus.sel_b;
        if (m_live) begin
            chk("cap_valid", bus.cap_valid, m_mode == MSend);
            chk("cap_sop", bus.cap_sop, m_mode == MSend && m_sent == 0);
            chk("cap_eop", bus.cap_eop, m_mode == MSend && m_sent == N - 1);
            chk("pair", pc, pair_code(m_pair));
            chk("result_strobe", bus.result_strobe, m_strobe);
            chk("busy", bus.busy, m_mode >= MSend);
            chk("overrun", bus.overrun, m_over);
            chk("timeout_err", bus.timeout_err, m_terr);
        end
        if (bus.cap_valid) valid_cnt++;
        if (bus.cap_valid && bus.fft_ready && rst_n) begin
            acc_cnt++;
            if (bus.cap_sop) begin sop_cnt++; frame_pairs.push_back(pc); end
            if (bus.cap_eop) eop_cnt++;
        end
        if (bus.result_strobe) begin strobe_cnt++; strobe_pairs.push_back(pc); end
        if (bus.busy && !bus.cap_valid) post_cnt++;
    end

    int done_cnt = 0, done_delay = 2, stall_left = 0;
    bit rand_mode = 0;

    // One cycle: inputs change just after the falling edge, away from the sampling edge.
    task automatic step();
        int d;
        @(negedge clk);
        #1;
        bus.fft_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) bus.fft_done = 1'b1;
        end
        if (rand_mode) begin
            bus.fft_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(39, 0) == 0) bus.fft_done = 1'b1;
            if ($urandom_range(149, 0) == 0) bus.enable = ~bus.enable;
        end else if (stall_left > 0) begin
            bus.fft_ready = 1'b0;
            stall_left--;
        end else begin
            bus.fft_ready = 1'b1;
        end
        if (bus.cap_valid && bus.cap_eop && bus.fft_ready) begin
            d = rand_mode ? int'($urandom_range(24, 0)) : done_delay;
            if (d > 0) done_cnt = d;
        end
    endtask

    task automatic clear_mon();
        acc_cnt = 0; sop_cnt = 0; eop_cnt = 0; valid_cnt = 0; strobe_cnt = 0; post_cnt = 0;
        frame_pairs.delete();
        strobe_pairs.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        done_cnt = 0;
        stall_left = 0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int n;
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.fft_ready = 1'b1;
        bus.fft_done = 1'b0;
        repeat (3) step();
        chk("rst_cap_valid", bus.cap_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_timeout", bus.timeout_err, 0);
        chk("rst_strobe", bus.result_strobe, 0);
        chk("rst_pair", bus.sel_a * 16 + bus.sel_b, 'h01);
        rst_n = 1'b1;

        // Single clean frame, then three more back to back.
        clear_mon();
        done_delay = 2;
        bus.enable = 1'b1;
        n = 0; while (strobe_cnt < 1 && n < 80) begin step(); n++; end
        chk("f1_strobe", strobe_cnt, 1);
        chk("f1_accepts", acc_cnt, 8);
        chk("f1_valid_cycles", valid_cnt, 8);
        chk("f1_sop", sop_cnt, 1);
        chk("f1_eop", eop_cnt, 1);
        chk("f1_pair", strobe_pairs.size() > 0 ? strobe_pairs[0] : -1, 'h01);
        n = 0; while (strobe_cnt < 4 && n < 120) begin step(); n++; end
        chk("f4_strobes", strobe_cnt, 4);
        chk("f4_pair1", strobe_pairs.size() > 1 ? strobe_pairs[1] : -1, 'h02);
        chk("f4_pair2", strobe_pairs.size() > 2 ? strobe_pairs[2] : -1, 'h12);
        chk("f4_pair3", strobe_pairs.size() > 3 ? strobe_pairs[3] : -1, 'h01);
        chk("f4_overrun", bus.overrun, 0);

        // Three-cycle stall mid-frame.
        do_reset();
        clear_mon();
        n = 0; while (acc_cnt < 4 && n < 60) begin step(); n++; end
        stall_left = 3;
        n = 0; while (strobe_cnt < 1 && n < 80) begin step(); n++; end
        chk("st_strobe", strobe_cnt, 1);
        chk("st_accepts", acc_cnt, 8);
        chk("st_valid_cycles", valid_cnt, 11);
        chk("st_sop", sop_cnt, 1);
        chk("st_eop", eop_cnt, 1);
        chk("st_overrun", bus.overrun, 1);

        // FFT never answers: timeout, then the next frame on the next pair.
        do_reset();
        clear_mon();
        done_delay = 0;
        n = 0; while (frame_pairs.size() < 2 && n < 120) begin step(); n++; end
        chk("to_err", bus.timeout_err, 1);
        chk("to_strobe", strobe_cnt, 0);
        chk("to_post_cycles", post_cnt, TIMEOUT + 1);
        chk("to_pair0", frame_pairs.size() > 0 ? frame_pairs[0] : -1, 'h01);
        chk("to_pair1", frame_pairs.size() > 1 ? frame_pairs[1] : -1, 'h02);

        // Reset with four samples taken.
        do_reset();
        clear_mon();
        done_delay = 2;
        n = 0; while (acc_cnt < 4 && n < 60) begin step(); n++; end
        step();
        rst_n = 1'b0;
        step();
        chk("mr_cap_valid", bus.cap_valid, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_overrun", bus.overrun, 0);
        chk("mr_pair", bus.sel_a * 16 + bus.sel_b, 'h01);
        rst_n = 1'b1;
        clear_mon();
        n = 0; while (strobe_cnt < 1 && n < 80) begin step(); n++; end
        chk("mr_next_sop", sop_cnt, 1);
        chk("mr_next_accepts", acc_cnt, 8);
        chk("mr_next_pair", strobe_pairs.size() > 0 ? strobe_pairs[0] : -1, 'h01);

        // Enable dropped while waiting for the FFT result.
        do_reset();
        clear_mon();
        done_delay = 4;
        n = 0; while (eop_cnt < 1 && n < 60) begin step(); n++; end
        step();
        bus.enable = 1'b0;
        n = 0; while (strobe_cnt < 1 && n < 40) begin step(); n++; end
        repeat (40) step();
        chk("en_strobe", strobe_cnt, 1);
        chk("en_valid_cycles", valid_cnt, 8);
        chk("en_busy", bus.busy, 0);

        // Randomized soak; the per-cycle model does the checking.
        do_reset();
        bus.enable = 1'b1;
        rand_mode = 1;
        repeat (2000) step();
        rand_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
